// File: rtl/pipelined_sub_64.sv
// Pipelined carry-select subtractor: computes a - b - bin one BLOCK_WIDTH slice per stage,
// with valid/ready handshakes on both sides and borrow, signed-overflow and zero flags.
module pipelined_sub_64 #(
  parameter int WIDTH       = 64,
  parameter int BLOCK_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / BLOCK_WIDTH;
  localparam int BW     = BLOCK_WIDTH;

  // Both candidate sums of x + ~y are formed; the incoming carry only picks one.
  function automatic logic [BW:0] block_sum(input logic [BW-1:0] x,
                                            input logic [BW-1:0] y,
                                            input logic          cin);
    logic [BW:0] sum_c0;
    logic [BW:0] sum_c1;
    sum_c0 = {1'b0, x} + {1'b0, ~y};
    sum_c1 = {1'b0, x} + {1'b0, ~y} + {{BW{1'b0}}, 1'b1};
    return cin ? sum_c1 : sum_c0;
  endfunction

  logic             adv;
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] z_q, z_d;
  logic [STAGES-1:0] am_q, am_d;
  logic [STAGES-1:0] bm_q, bm_d;
  logic [WIDTH-1:0] d_q  [STAGES];
  logic [WIDTH-1:0] d_d  [STAGES];
  logic [WIDTH-1:0] ra_q [STAGES-1];
  logic [WIDTH-1:0] ra_d [STAGES-1];
  logic [WIDTH-1:0] rb_q [STAGES-1];
  logic [WIDTH-1:0] rb_d [STAGES-1];
  logic [BW:0]      blk  [STAGES];

  assign adv      = ~v_q[STAGES-1] | out_ready;
  assign in_ready = adv & ~rst;

  // Next-state for every stage; the remaining operands shift down so the next
  // stage always works on the low BW bits.
  always_comb begin
    blk[0]     = block_sum(a[BW-1:0], b[BW-1:0], ~bin);
    v_d[0]     = in_valid & in_ready;
    c_d[0]     = blk[0][BW];
    d_d[0]     = '0;
    d_d[0][BW-1:0] = blk[0][BW-1:0];
    z_d[0]     = (blk[0][BW-1:0] == '0);
    am_d[0]    = a[WIDTH-1];
    bm_d[0]    = b[WIDTH-1];
    ra_d[0]    = a >> BW;
    rb_d[0]    = b >> BW;
    for (int k = 1; k < STAGES; k++) begin
      blk[k] = block_sum(ra_q[k-1][BW-1:0], rb_q[k-1][BW-1:0], c_q[k-1]);
      v_d[k] = v_q[k-1];
      c_d[k] = blk[k][BW];
      d_d[k] = d_q[k-1];
      d_d[k][k*BW +: BW] = blk[k][BW-1:0];
      z_d[k]  = z_q[k-1] & (blk[k][BW-1:0] == '0);
      am_d[k] = am_q[k-1];
      bm_d[k] = bm_q[k-1];
    end
    for (int k = 1; k < STAGES-1; k++) begin
      ra_d[k] = ra_q[k-1] >> BW;
      rb_d[k] = rb_q[k-1] >> BW;
    end
  end

  // Carries reset to 1 so the inverted top carry presents bout = 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      c_q  <= '1;
      z_q  <= '0;
      am_q <= '0;
      bm_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d_q[k] <= '0;
      end
      for (int k = 0; k < STAGES-1; k++) begin
        ra_q[k] <= '0;
        rb_q[k] <= '0;
      end
    end else if (adv) begin
      v_q  <= v_d;
      c_q  <= c_d;
      z_q  <= z_d;
      am_q <= am_d;
      bm_q <= bm_d;
      for (int k = 0; k < STAGES; k++) begin
        d_q[k] <= d_d[k];
      end
      for (int k = 0; k < STAGES-1; k++) begin
        ra_q[k] <= ra_d[k];
        rb_q[k] <= rb_d[k];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign diff      = d_q[STAGES-1];
  assign bout      = ~c_q[STAGES-1];
  assign zero      = z_q[STAGES-1];
  assign ovf       = (am_q[STAGES-1] ^ bm_q[STAGES-1]) &
                     (d_q[STAGES-1][WIDTH-1] ^ am_q[STAGES-1]);

endmodule

// File: tb/tb_pipelined_sub_64.sv
// Self-checking bench for pipelined_sub_64: directed vector table, backpressure,
// mid-flight reset and a random soak against a 65-bit arithmetic reference.
module tb_pipelined_sub_64;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } vec_t;

  typedef struct packed {
    logic [63:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  int   checks;
  int   passes;
  int   accepted;
  int   retired;
  res_t exp_q[$];
  vec_t vec[11];

  pipelined_sub_64 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference built from wide unsigned/signed arithmetic rather than block carries.
  function automatic res_t golden(input logic [63:0] ga, input logic [63:0] gb, input logic gbin);
    res_t r;
    logic [64:0] u;
    logic [64:0] s;
    u = {1'b0, ga} - {1'b0, gb} - {64'd0, gbin};
    s = {ga[63], ga} - {gb[63], gb} - {64'd0, gbin};
    r.diff = u[63:0];
    r.bout = u[64];
    r.ovf  = s[64] ^ s[63];
    r.zero = (u[63:0] == 64'd0);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Single isolated beat: checks acceptance, 3-edge latency, values and no duplicate.
  task automatic applyStimulus(input vec_t v, input string name);
    int lat;
    in_valid  = 1'b1;
    a         = v.a;
    b         = v.b;
    bin       = v.bin;
    out_ready = 1'b1;
    #1;
    checkOutput({name, "_in_ready"}, {66'd0, in_ready}, 67'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_latency"}, 67'(lat), 67'd3);
    checkOutput({name, "_diff"}, {3'd0, diff}, {3'd0, v.diff});
    checkOutput({name, "_bout"}, {66'd0, bout}, {66'd0, v.bout});
    checkOutput({name, "_ovf"},  {66'd0, ovf},  {66'd0, v.ovf});
    checkOutput({name, "_zero"}, {66'd0, zero}, {66'd0, v.zero});
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, "_drained"}, {66'd0, out_valid}, 67'd0);
  endtask

  // One streaming cycle, entered and left at a falling edge.
  task automatic cycleStep(input logic iv, input logic [63:0] ia, input logic [63:0] ib,
                           input logic ibin, input logic ordy, input string tag,
                           output logic acc);
    res_t e;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    bin       = ibin;
    out_ready = ordy;
    #1;
    acc = iv & in_ready;
    if (out_valid && !ordy) begin
      checkOutput({tag, "_stall_in_ready"}, {66'd0, in_ready}, 67'd0);
      if (exp_q.size() > 0)
        checkOutput({tag, "_stall_hold"}, {diff, bout, ovf, zero}, exp_q[0]);
    end
    if (out_valid && ordy) begin
      retired++;
      if (exp_q.size() == 0) begin
        checkOutput({tag, "_spurious_result"}, 67'd1, 67'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput({tag, "_result"}, {diff, bout, ovf, zero}, e);
      end
    end
    if (acc) begin
      exp_q.push_back(golden(ia, ib, ibin));
      accepted++;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] va [8];
    logic [63:0] vb [8];
    logic        vbin [8];
    logic        acc;
    logic        seen;
    logic        have;
    logic [63:0] sa;
    logic [63:0] sb;
    logic        sbin;
    int          idx;
    int          cyc;
    vec_t        v;

    checks = 0;
    passes = 0;
    vec[0]  = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vec[2]  = '{64'h0001_0000_0000_0000, 64'd1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{64'h8000_0000_0000_0000, 64'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
    vec[4]  = '{64'h1234, 64'h1234, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
    vec[5]  = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vec[6]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0};
    vec[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vec[8]  = '{64'h0000_0000_0001_0000, 64'd1, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b0};
    vec[9]  = '{64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
    vec[10] = '{64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b0,
                64'hFFFE_0001_FFFE_0001, 1'b0, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", {66'd0, out_valid}, 67'd0);
    checkOutput("reset_diff", {3'd0, diff}, 67'd0);
    checkOutput("reset_flags", {64'd0, bout, ovf, zero}, 67'd0);
    checkOutput("reset_in_ready", {66'd0, in_ready}, 67'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", {66'd0, in_ready}, 67'd1);
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      applyStimulus(vec[i], $sformatf("vec%0d", i));

    // Eight back-to-back beats with out_ready low for three cycles mid-stream.
    for (int i = 0; i < 8; i++) begin
      va[i]   = {$urandom, $urandom};
      vb[i]   = {$urandom, $urandom};
      vbin[i] = 1'($urandom_range(0, 1));
    end
    accepted = 0;
    retired  = 0;
    idx      = 0;
    cyc      = 0;
    while ((idx < 8 || exp_q.size() > 0) && cyc < 100) begin
      if (idx < 8)
        cycleStep(1'b1, va[idx], vb[idx], vbin[idx], !(cyc >= 5 && cyc < 8), "bp", acc);
      else
        cycleStep(1'b0, 64'd0, 64'd0, 1'b0, 1'b1, "bp", acc);
      if (acc) idx++;
      cyc++;
    end
    checkOutput("bp_timeout", {66'd0, cyc >= 100}, 67'd0);
    checkOutput("bp_count", 67'(retired), 67'd8);

    // Reset with three beats in flight: none of them may ever emerge.
    for (int i = 0; i < 3; i++)
      cycleStep(1'b1, 64'd100 + 64'(i), 64'd1, 1'b0, 1'b1, "midrst", acc);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    checkOutput("midrst_in_ready", {66'd0, in_ready}, 67'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkOutput("midrst_no_result", {66'd0, seen}, 67'd0);
    v = '{64'd10, 64'd4, 1'b0, 64'd6, 1'b0, 1'b0, 1'b0};
    applyStimulus(v, "after_rst");

    // Random soak with random upstream valid and downstream ready.
    accepted = 0;
    retired  = 0;
    have     = 1'b0;
    sa       = '0;
    sb       = '0;
    sbin     = 1'b0;
    cyc      = 0;
    while ((accepted < 10000 || exp_q.size() > 0) && cyc < 80000) begin
      if (!have && accepted < 10000 && $urandom_range(0, 3) != 0) begin
        sa   = {$urandom, $urandom};
        sb   = ($urandom_range(0, 7) == 0) ? sa : {$urandom, $urandom};
        sbin = 1'($urandom_range(0, 1));
        have = 1'b1;
      end
      cycleStep(have, sa, sb, sbin, $urandom_range(0, 3) != 0, "soak", acc);
      if (acc) have = 1'b0;
      cyc++;
    end
    checkOutput("soak_timeout", {66'd0, cyc >= 80000}, 67'd0);
    checkOutput("soak_count", 67'(retired), 67'(accepted));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
